// File: rtl/ir_matrix_scanner.sv
// ir_matrix_scanner: scans a 4x4 IR beam matrix row by row and debounces each cell into an active-low ir_out vector
//   Ports: clk, resetn (async active-low) | row_drv_n[3:0] one-hot active-low row drive
//          col_sense_n[3:0] async column returns (0 = beam broken) | clear_traces sync clear (sticky build only)
//          ir_out[15:0] debounced cell state, index row*4+col, 0 = broken
//          scan_done pulse after each full scan | ir_changed pulse after any ir_out change
//   Build option: define IR_STICKY_TRACE_EN to latch broken cells until clear_traces.
module ir_matrix_scanner #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [3:0]  row_drv_n,
    input  logic [3:0]  col_sense_n,
    input  logic        clear_traces,
    output logic [15:0] ir_out,
    output logic        scan_done,
    output logic        ir_changed
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    logic [1:0]    state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    row_drv_q, row_drv_d;
    logic [15:0]   ir_q, ir_d;
    logic          scan_done_q, ir_changed_q;
    logic [DW-1:0] deb_q [16];
    logic [DW-1:0] deb_d [16];
    logic [3:0]    idx;
    logic          s;
`ifndef IR_STICKY_TRACE_EN
    logic unused_clear;
    assign unused_clear = clear_traces;
`endif
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            state_d = DRIVE;
            cnt_d   = '0;
        end else if (state_q == DRIVE) begin
            if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
            else cnt_d = cnt_q + 1'b1;
        end else begin
            state_d = DRIVE;
            row_d   = row_q + 1'b1;
            cnt_d   = '0;
        end
        // Drive is registered from next state so the row line tracks the FSM exactly.
        row_drv_d = (state_d == IDLE) ? 4'hF : ~(4'b0001 << row_d);
    end
    always_comb begin
        ir_d  = ir_q;
        deb_d = deb_q;
        idx   = '0;
        s     = 1'b0;
        if (state_q == SAMPLE) begin
            for (int c = 0; c < 4; c++) begin
                idx = {row_q, c[1:0]};
                s   = sync2_q[c];
`ifdef IR_STICKY_TRACE_EN
                // A latched broken cell sees any idle sample as agreement, so it never releases.
                s = s & ir_q[idx];
`endif
                if (s == ir_q[idx]) deb_d[idx] = '0;
                else if (deb_q[idx] == DW'(DEBOUNCE_COUNT - 1)) begin
                    ir_d[idx]  = s;
                    deb_d[idx] = '0;
                end else deb_d[idx] = deb_q[idx] + 1'b1;
            end
        end
`ifdef IR_STICKY_TRACE_EN
        if (clear_traces) begin
            ir_d = '1;
            for (int i = 0; i < 16; i++) deb_d[i] = '0;
        end
`endif
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            row_q        <= '0;
            cnt_q        <= '0;
            sync1_q      <= 4'hF;
            sync2_q      <= 4'hF;
            row_drv_q    <= 4'hF;
            ir_q         <= 16'hFFFF;
            scan_done_q  <= 1'b0;
            ir_changed_q <= 1'b0;
            deb_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            sync1_q      <= col_sense_n;
            sync2_q      <= sync1_q;
            row_drv_q    <= row_drv_d;
            ir_q         <= ir_d;
            scan_done_q  <= (state_q == SAMPLE) && (row_q == 2'd3);
            ir_changed_q <= ir_d != ir_q;
            deb_q        <= deb_d;
        end
    end
    assign row_drv_n  = row_drv_q;
    assign ir_out     = ir_q;
    assign scan_done  = scan_done_q;
    assign ir_changed = ir_changed_q;
endmodule
